// File: rtl/window_index_gen.sv
// Walks a KxK window around a centre pixel in raster order and emits one linear address per tap.
// Latency 1 from start to tap 0; the tap holds under addr_ready=0; outputs are registered.
module window_index_gen #(
  parameter int ROWS   = 64,
  parameter int COLS   = 64,
  parameter int K      = 3,
  parameter int IDX_W  = 6,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [IDX_W-1:0]  row,
  input  logic [IDX_W-1:0]  col,
  input  logic              mode,
  output logic              busy,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic [ADDR_W-1:0] addr,
  output logic [4:0]        tap,
  output logic              addr_oob,
  output logic              last,
  output logic              done,
  output logic              err
);

  localparam int R  = (K - 1) / 2;
  localparam int SW = IDX_W + 2;
  localparam logic [2:0]           KM1     = 3'(K - 1);
  localparam logic signed [SW-1:0] ROW_MAX = SW'(ROWS - 1);
  localparam logic signed [SW-1:0] COL_MAX = SW'(COLS - 1);
  localparam logic signed [SW-1:0] R_S     = SW'(R);
  localparam logic [IDX_W:0]       ROWS_L  = (IDX_W + 1)'(ROWS);
  localparam logic [IDX_W:0]       COLS_L  = (IDX_W + 1)'(COLS);

  typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

  state_t            state_q;
  logic [IDX_W-1:0]  row_q, col_q;
  logic              mode_q;
  logic [2:0]        ti_q, tj_q;
  logic              busy_q, valid_q, oob_q, last_q, done_q, err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [4:0]        tap_q;

  logic [IDX_W-1:0]    sel_row, sel_col;
  logic                sel_mode;
  logic [2:0]          ti_d, tj_d;
  logic signed [SW-1:0] r_s, c_s, r_cl, c_cl;
  logic                r_out, c_out, oob_d, last_d, centre_bad;
  logic [ADDR_W-1:0]   addr_d;
  logic [4:0]          tap_d;

  // In IDLE the next tap is tap 0 of the incoming request; in EMIT it is the successor tap.
  always_comb begin
    sel_row  = row;
    sel_col  = col;
    sel_mode = mode;
    ti_d     = '0;
    tj_d     = '0;
    if (state_q == EMIT) begin
      sel_row  = row_q;
      sel_col  = col_q;
      sel_mode = mode_q;
      if (tj_q == KM1) begin
        ti_d = ti_q + 3'd1;
        tj_d = '0;
      end else begin
        ti_d = ti_q;
        tj_d = tj_q + 3'd1;
      end
    end
    r_s   = $signed({2'b00, sel_row}) + $signed(SW'(ti_d)) - R_S;
    c_s   = $signed({2'b00, sel_col}) + $signed(SW'(tj_d)) - R_S;
    r_out = r_s[SW-1] || (r_s > ROW_MAX);
    c_out = c_s[SW-1] || (c_s > COL_MAX);
    r_cl  = r_s[SW-1] ? '0 : ((r_s > ROW_MAX) ? ROW_MAX : r_s);
    c_cl  = c_s[SW-1] ? '0 : ((c_s > COL_MAX) ? COL_MAX : c_s);
    oob_d = sel_mode && (r_out || c_out);
    addr_d = oob_d ? '0
           : ADDR_W'($unsigned(r_cl)) * ADDR_W'(COLS) + ADDR_W'($unsigned(c_cl));
    tap_d  = 5'(ti_d) * 5'(K) + 5'(tj_d);
    last_d = (ti_d == KM1) && (tj_d == KM1);
    centre_bad = ({1'b0, row} >= ROWS_L) || ({1'b0, col} >= COLS_L);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      mode_q  <= 1'b0;
      ti_q    <= '0;
      tj_q    <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      oob_q   <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      tap_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          err_q  <= 1'b0;
          if (start) begin
            row_q  <= row;
            col_q  <= col;
            mode_q <= mode;
            busy_q <= 1'b1;
            if (centre_bad) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q <= EMIT;
              valid_q <= 1'b1;
              ti_q    <= ti_d;
              tj_q    <= tj_d;
              addr_q  <= addr_d;
              tap_q   <= tap_d;
              oob_q   <= oob_d;
              last_q  <= last_d;
            end
          end
        end
        EMIT: begin
          if (addr_ready) begin
            if (last_q) begin
              state_q <= DONE;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              oob_q   <= 1'b0;
              done_q  <= 1'b1;
              err_q   <= 1'b0;
            end else begin
              ti_q   <= ti_d;
              tj_q   <= tj_d;
              addr_q <= addr_d;
              tap_q  <= tap_d;
              oob_q  <= oob_d;
              last_q <= last_d;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign addr_valid = valid_q;
  assign addr       = addr_q;
  assign tap        = tap_q;
  assign addr_oob   = oob_q;
  assign last       = last_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_window_index_gen.sv
// Directed bench for window_index_gen: default 64x64 instance plus a ROWS=48 instance for range errors.
module tb_window_index_gen;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start, mode, addr_ready;
  logic [5:0]  row, col;
  logic        busy, addr_valid, addr_oob, last, done, err;
  logic [11:0] addr;
  logic [4:0]  tap;

  logic        start2, mode2, ready2;
  logic [5:0]  row2, col2;
  logic        busy2, valid2, oob2, last2, done2, err2;
  logic [11:0] addr2;
  logic [4:0]  tap2;

  int checks = 0;
  int errors = 0;
  int xfers;

  window_index_gen dut (
    .clk(clk), .rst(rst), .start(start), .row(row), .col(col), .mode(mode),
    .busy(busy), .addr_valid(addr_valid), .addr_ready(addr_ready), .addr(addr),
    .tap(tap), .addr_oob(addr_oob), .last(last), .done(done), .err(err)
  );

  window_index_gen #(.ROWS(48)) dut48 (
    .clk(clk), .rst(rst), .start(start2), .row(row2), .col(col2), .mode(mode2),
    .busy(busy2), .addr_valid(valid2), .addr_ready(ready2), .addr(addr2),
    .tap(tap2), .addr_oob(oob2), .last(last2), .done(done2), .err(err2)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " busy"},  int'(busy), 0);
    chk({tag, " valid"}, int'(addr_valid), 0);
    chk({tag, " done"},  int'(done), 0);
    chk({tag, " err"},   int'(err), 0);
    chk({tag, " last"},  int'(last), 0);
    chk({tag, " oob"},   int'(addr_oob), 0);
    chk({tag, " addr"},  int'(addr), 0);
    chk({tag, " tap"},   int'(tap), 0);
  endtask

  // Full window with ready held high; ea/eo are the hand-computed address and oob per tap.
  task automatic run_win(input string tag, input int r, input int c, input int m,
                         input int ea[9], input int eo[9]);
    row = 6'(r); col = 6'(c); mode = m[0]; start = 1'b1; addr_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("%s valid t%0d", tag, k), int'(addr_valid), 1);
      chk($sformatf("%s tap t%0d", tag, k), int'(tap), k);
      chk($sformatf("%s addr t%0d", tag, k), int'(addr), ea[k]);
      chk($sformatf("%s oob t%0d", tag, k), int'(addr_oob), eo[k]);
      chk($sformatf("%s last t%0d", tag, k), int'(last), (k == 8) ? 1 : 0);
      chk($sformatf("%s busy t%0d", tag, k), int'(busy), 1);
      tick();
    end
    chk({tag, " done"}, int'(done), 1);
    chk({tag, " err"}, int'(err), 0);
    chk({tag, " valid after"}, int'(addr_valid), 0);
    chk({tag, " busy in done"}, int'(busy), 1);
    tick();
    chk({tag, " done pulse ends"}, int'(done), 0);
    chk({tag, " busy idle"}, int'(busy), 0);
  endtask

  initial begin
    int ea[9];
    int eo[9];
    rst = 1'b1; start = 1'b0; row = '0; col = '0; mode = 1'b0; addr_ready = 1'b0;
    start2 = 1'b0; row2 = '0; col2 = '0; mode2 = 1'b0; ready2 = 1'b1;
    #3;
    chk_idle_outputs("reset");
    tick();
    rst = 1'b0;
    tick();

    ea = '{595, 596, 597, 659, 660, 661, 723, 724, 725};
    eo = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    run_win("centre10_20", 10, 20, 0, ea, eo);

    ea = '{0, 0, 1, 0, 0, 1, 64, 64, 65};
    run_win("corner_clamp", 0, 0, 0, ea, eo);

    ea = '{0, 0, 0, 0, 0, 1, 0, 64, 65};
    eo = '{1, 1, 1, 1, 0, 0, 1, 0, 0};
    run_win("corner_pad", 0, 0, 1, ea, eo);

    // Backpressure at tap 4; a start with other coordinates is held to prove it is ignored.
    ea = '{595, 596, 597, 659, 660, 661, 723, 724, 725};
    xfers = 0;
    row = 6'd10; col = 6'd20; mode = 1'b0; start = 1'b1; addr_ready = 1'b1;
    tick();
    row = 6'd0; col = 6'd0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("stall tap t%0d", k), int'(tap), k);
      chk($sformatf("stall addr t%0d", k), int'(addr), ea[k]);
      if (addr_valid && addr_ready) xfers++;
      tick();
    end
    addr_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      #2;
      chk($sformatf("held valid s%0d", s), int'(addr_valid), 1);
      chk($sformatf("held tap s%0d", s), int'(tap), 4);
      chk($sformatf("held addr s%0d", s), int'(addr), 660);
      tick();
    end
    addr_ready = 1'b1;
    for (int k = 4; k < 9; k++) begin
      chk($sformatf("resume tap t%0d", k), int'(tap), k);
      chk($sformatf("resume addr t%0d", k), int'(addr), ea[k]);
      if (addr_valid && addr_ready) xfers++;
      if (k == 8) start = 1'b0;
      tick();
    end
    chk("stall transfers", xfers, 9);
    chk("stall done", int'(done), 1);
    tick();
    chk("stall back idle", int'(busy), 0);
    chk("stall no restart", int'(addr_valid), 0);

    // Reset in the middle of a window, after tap 3 has been accepted.
    row = 6'd10; col = 6'd20; mode = 1'b0; start = 1'b1; addr_ready = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("pre-rst tap", int'(tap), 4);
    rst = 1'b1;
    #1;
    chk_idle_outputs("midrst");
    tick();
    rst = 1'b0;
    row = 6'd1; col = 6'd1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("post-rst valid", int'(addr_valid), 1);
    chk("post-rst tap", int'(tap), 0);
    chk("post-rst addr", int'(addr), 0);
    repeat (9) tick();
    chk("post-rst done", int'(done), 1);
    tick();

    // Centre row outside a 48-row image: straight to DONE with err.
    row2 = 6'd50; col2 = 6'd0; start2 = 1'b1;
    tick();
    row2 = 6'd1; col2 = 6'd1;
    chk("range valid", int'(valid2), 0);
    chk("range done", int'(done2), 1);
    chk("range err", int'(err2), 1);
    chk("range busy", int'(busy2), 1);
    tick();
    start2 = 1'b0;
    chk("range done pulse", int'(done2), 0);
    chk("range err pulse", int'(err2), 0);
    chk("range busy start ignored", int'(busy2), 0);
    tick();
    chk("range no emit", int'(valid2), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/window_index_gen.md
WINDOW_INDEX_GEN -- requirements
Module: window_index_gen

Interface
REQ-001 SHALL have parameter ROWS, default 64, image height in pixels.
REQ-002 SHALL have parameter COLS, default 64, image width in pixels (row pitch).
REQ-003 SHALL have parameter K, default 3, window side; odd, 1..5; R=(K-1)/2.
REQ-004 SHALL have parameter IDX_W, default 6, width of row/col inputs.
REQ-005 SHALL have parameter ADDR_W, default 12, linear address width; ROWS*COLS <= 2^ADDR_W.
REQ-006 SHALL have port clk  input  1  sole clock, rising edge.
REQ-007 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port start  input  1  request; row/col/mode captured with it.
REQ-009 SHALL have port row  input  IDX_W  centre row, unsigned.
REQ-010 SHALL have port col  input  IDX_W  centre column, unsigned.
REQ-011 SHALL have port mode  input  1  0 = clamp to edge, 1 = zero-pad (flag out-of-bounds).
REQ-012 SHALL have port busy  output  1  high in EMIT and DONE.
REQ-013 SHALL have port addr_valid  output  1  addr/tap/oob/last valid.
REQ-014 SHALL have port addr_ready  input  1  consumer accepts current tap.
REQ-015 SHALL have port addr  output  ADDR_W  linear pixel index r*COLS+c.
REQ-016 SHALL have port tap  output  5  tap number 0..K*K-1.
REQ-017 SHALL have port addr_oob  output  1  tap lies outside image (mode 1 only).
REQ-018 SHALL have port last  output  1  current tap is K*K-1.
REQ-019 SHALL have port done  output  1  one-cycle completion pulse.
REQ-020 SHALL have port err  output  1  valid with done; centre out of range.

Function
REQ-021 SHALL implement FSM IDLE -> EMIT -> DONE -> IDLE.
REQ-022 IDLE: start=1 at edge t SHALL capture row/col/mode; EMIT with addr_valid=1, tap=0 from t+1 (latency 1).
REQ-023 start SHALL be ignored while busy=1.
REQ-024 Centre row>=ROWS or col>=COLS SHALL go IDLE -> DONE at t+1 with done=err=1, no addr_valid.
REQ-025 Tap order SHALL be raster: dr=-R..+R outer, dc=-R..+R inner; tap = (dr+R)*K + (dc+R).
REQ-026 Coordinates row+dr, col+dc SHALL use signed IDX_W+2-bit arithmetic; no wrap (col 0, dc -1 gives -1, not 2^IDX_W-1).
REQ-027 mode 0: r,c SHALL clamp to [0,ROWS-1], [0,COLS-1]; addr_oob=0.
REQ-028 mode 1: out-of-range tap SHALL give addr=0, addr_oob=1; in-range tap SHALL give true address, addr_oob=0.
REQ-029 addr SHALL be r*COLS+c, unsigned, ADDR_W bits.
REQ-030 Transfer SHALL occur on edge with addr_valid & addr_ready; tap advances by one per transfer only.
REQ-031 addr, tap, addr_oob, last SHALL hold stable while addr_valid=1 and addr_ready=0.
REQ-032 Transfer with last=1 SHALL enter DONE: addr_valid=0, done=1, err=0 for exactly one cycle, then IDLE.
REQ-033 Outputs SHALL be registered; addr_valid=0 in IDLE and DONE.

Reset
REQ-034 rst=1 SHALL immediately force IDLE, busy=addr_valid=done=err=last=addr_oob=0, addr=0, tap=0, regardless of clk.
REQ-035 Reset mid-EMIT SHALL discard the request; next start after rst release SHALL begin at tap 0.

Verification
REQ-036 Defaults, (10,20), mode 0, ready=1: addr 595,596,597,659,660,661,723,724,725 on cycles t+1..t+9; last on 9th; done=1 at t+10.
REQ-037 (0,0), mode 0: addr 0,0,1,0,0,1,64,64,65; addr_oob all 0.
REQ-038 (0,0), mode 1: taps 0,1,2,3,6 addr=0 oob=1; taps 4,5,7,8 addr 0,1,64,65 oob=0.
REQ-039 (10,20), ready low 3 cycles at tap 4: addr=660, tap=4 held 3 cycles; 9 transfers total, no skip/duplicate.
REQ-040 rst pulse after tap 3 accepted: outputs zero same cycle; new start (1,1) yields tap 0 addr 0.
REQ-041 ROWS=48, start row=50: no addr_valid, done=err=1 at t+1; start during busy ignored.
